// File: rtl/fir_hls_pkg.sv
// Shared definitions for the FIR HLS sequential divider.
// Contents:
//   - operand / result widths
//   - bit-counter width and load value
//   - FSM state encoding
//   - quotient saturation constants
package fir_hls_pkg;

  localparam int DIVIDEND_WIDTH = 31;
  localparam int DIVISOR_WIDTH  = 15;
  localparam int QUOTIENT_WIDTH = 16;

  // The partial remainder is always below the divisor. One extra bit holds
  // the shifted value before the trial subtract, and also lets the signed
  // remainder output represent -(2^15-1).
  localparam int REM_WIDTH = DIVISOR_WIDTH + 1;

  localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [QUOTIENT_WIDTH-1:0] QMAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] QMIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

  // Largest quotient magnitudes that fit without clipping:
  //   - QPOS_LIMIT for a positive result
  //   - QNEG_LIMIT for a negative result (one more, because -2^(Q-1) is representable)
  localparam logic [DIVIDEND_WIDTH-1:0] QPOS_LIMIT = DIVIDEND_WIDTH'(QMAX);
  localparam logic [DIVIDEND_WIDTH-1:0] QNEG_LIMIT = DIVIDEND_WIDTH'(QMAX) + DIVIDEND_WIDTH'(1);

endpackage

// File: rtl/fir_hls_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : unsigned divisor
//   rem_o     : partial remainder after this iteration
//   q_o       : quotient bit produced by this iteration
module fir_hls_div_step
  import fir_hls_pkg::*;
(
  input  logic [REM_WIDTH-1:0]     rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [REM_WIDTH-1:0]     rem_o,
  output logic                     q_o
);

  // Widen by one bit so the shift never loses the remainder MSB.
  logic [REM_WIDTH:0] shifted;
  logic [REM_WIDTH:0] divisor_ext;

  assign shifted     = {rem_i, bit_i};
  assign divisor_ext = {2'b00, divisor_i};

  // Trial subtract: keep the difference only when it does not go negative.
  // Either result is below the divisor, so it fits back in REM_WIDTH bits.
  assign q_o   = (shifted >= divisor_ext);
  assign rem_o = q_o ? REM_WIDTH'(shifted - divisor_ext) : REM_WIDTH'(shifted);

endmodule

// File: rtl/fir_hls_div_31s_15ns_16s_seq.sv
// Sequential signed-by-unsigned restoring divider for the FIR output path.
// Inputs and outputs:
//   - a 31-bit signed dividend (din0) and a 15-bit unsigned divisor (din1)
//   - a saturated 16-bit signed quotient (dout), truncated toward zero
//   - a signed remainder (rem) whose sign follows the dividend
// One quotient bit is produced per clock.
//
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (din0, din1)
//   out_valid/out_ready : result handshake (dout, rem, ovf, dbz)
//   ovf : quotient was clipped, or the divisor was zero
//   dbz : divisor was zero
//   dbg_state_o : current FSM state (div_state_t encoding)
//
// Handshake rules:
//   - A transfer happens on a rising edge where valid and ready are both 1.
//   - in_ready is 1 only in IDLE.
//   - Once out_valid rises, the result stays stable and out_valid stays 1
//     until out_ready is seen.
//   - The producer may raise valid at any time; ready never waits on valid.
//
// Widths are fixed by the package (the module name encodes them). ID only
// tags the instance.
module fir_hls_div_31s_15ns_16s_seq
  import fir_hls_pkg::*;
#(
  parameter int ID = 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] dout,
  output logic [REM_WIDTH-1:0]      rem,
  output logic                      ovf,
  output logic                      dbz,
  output logic [1:0]                dbg_state_o
);

  if (ID < 0) begin : g_id_check
    $error("fir_hls_div_31s_15ns_16s_seq: ID must be non-negative");
  end

  div_state_t                state_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      neg_q;
  logic [DIVISOR_WIDTH-1:0]  dvsr_q;
  // Holds the dividend magnitude. Each RUN cycle shifts it left: its MSB
  // feeds the step and the new quotient bit enters at the LSB. After
  // DIVIDEND_WIDTH cycles it holds the unsigned quotient.
  logic [DIVIDEND_WIDTH-1:0] work_q;
  logic [REM_WIDTH-1:0]      prem_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [QUOTIENT_WIDTH-1:0] dout_q;
  logic [REM_WIDTH-1:0]      rem_q;
  logic                      ovf_q;
  logic                      dbz_q;

  logic [DIVIDEND_WIDTH-1:0] din0_mag;
  logic [REM_WIDTH-1:0]      step_rem_d;
  logic                      step_q_d;
  logic [QUOTIENT_WIDTH-1:0] dout_d;
  logic [REM_WIDTH-1:0]      rem_d;
  logic                      ovf_d;
  logic                      dbz_d;

  // |din0|. The most negative value -2^30 maps to 2^30, which still fits in
  // DIVIDEND_WIDTH unsigned bits.
  assign din0_mag = din0[DIVIDEND_WIDTH-1] ? (~din0 + 1'b1) : din0;

  fir_hls_div_step u_step (
    .rem_i     (prem_q),
    .bit_i     (work_q[DIVIDEND_WIDTH-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem_d),
    .q_o       (step_q_d)
  );

  // Sign restore and saturation. These values are used only on the FIX cycle.
  always_comb begin
    dout_d = '0;
    rem_d  = '0;
    ovf_d  = 1'b0;
    dbz_d  = 1'b0;
    if (dvsr_q == '0) begin
      dbz_d  = 1'b1;
      ovf_d  = 1'b1;
      dout_d = neg_q ? QMIN : QMAX;
    end else if (!neg_q) begin
      rem_d = prem_q;
      if (work_q > QPOS_LIMIT) begin
        ovf_d  = 1'b1;
        dout_d = QMAX;
      end else begin
        dout_d = work_q[QUOTIENT_WIDTH-1:0];
      end
    end else begin
      rem_d = -prem_q;
      if (work_q > QNEG_LIMIT) begin
        ovf_d  = 1'b1;
        dout_d = QMIN;
      end else begin
        // A magnitude of exactly 2^(Q-1) negates to QMIN in Q bits.
        dout_d = -work_q[QUOTIENT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      dvsr_q      <= '0;
      work_q      <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            neg_q      <= din0[DIVIDEND_WIDTH-1];
            work_q     <= din0_mag;
            dvsr_q     <= din1;
            prem_q     <= '0;
            cnt_q      <= CNT_INIT;
            in_ready_q <= 1'b0;
            // A zero divisor skips the iterations entirely.
            state_q    <= (din1 == '0) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          prem_q <= step_rem_d;
          work_q <= {work_q[DIVIDEND_WIDTH-2:0], step_q_d};
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIX: begin
          dout_q      <= dout_d;
          rem_q       <= rem_d;
          ovf_q       <= ovf_d;
          dbz_q       <= dbz_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign ovf         = ovf_q;
  assign dbz         = dbz_q;
  assign dbg_state_o = state_q;

endmodule
